// File: rtl/packet_picker.sv
// rtl/packet_picker.sv - picks and stages the next data island packet for the assembler
module packet_picker (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         packet_enable,
    input  logic [4:0]   packet_pixel_counter,
    input  logic         video_field_end,
    input  logic [3:0]   src_req,
    input  logic [95:0]  src_header,
    input  logic [895:0] src_sub,
    output logic [3:0]   src_ack,
    output logic [23:0]  header,
    output logic [55:0]  sub_0,
    output logic [55:0]  sub_1,
    output logic [55:0]  sub_2,
    output logic [55:0]  sub_3,
    output logic [2:0]   packet_type,
    output logic         acr_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STAGED  = 2'd1,
        ST_SENDING = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         acr_pend_q, acr_pend_d;
    logic         avi_pend_q, avi_pend_d;
    logic         aif_pend_q, aif_pend_d;
    logic         acr_overrun_q, acr_overrun_d;
    logic [23:0]  header_q, header_d;
    logic [55:0]  sub_0_q, sub_0_d;
    logic [55:0]  sub_1_q, sub_1_d;
    logic [55:0]  sub_2_q, sub_2_d;
    logic [55:0]  sub_3_q, sub_3_d;
    logic [2:0]   packet_type_q, packet_type_d;

    logic         stage;
    logic         sel_valid;
    logic [1:0]   sel;
    logic [3:0]   ack;
    logic         clr_acr;
    logic         clr_avi;
    logic         clr_aif;

    // Sources 2 and 3 have no request line; their request bits are tied off.
    logic         unused_req;
    assign unused_req = &{1'b0, src_req[3:2]};

    // Sequencing: IDLE stages once, SENDING restages on the last pixel of a packet.
    always_comb begin
        state_d = state_q;
        stage   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stage   = 1'b1;
                state_d = ST_STAGED;
            end
            ST_STAGED: begin
                if (packet_enable) begin
                    state_d = ST_SENDING;
                end
            end
            ST_SENDING: begin
                if (!packet_enable) begin
                    state_d = ST_STAGED;
                end else if (packet_pixel_counter == 5'd31) begin
                    stage = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Fixed priority: ACR, audio sample, AVI infoframe, audio infoframe.
    always_comb begin
        sel_valid = 1'b1;
        sel       = 2'd0;
        if (acr_pend_q) begin
            sel = 2'd0;
        end else if (src_req[1]) begin
            sel = 2'd1;
        end else if (avi_pend_q) begin
            sel = 2'd2;
        end else if (aif_pend_q) begin
            sel = 2'd3;
        end else begin
            sel_valid = 1'b0;
        end
    end

    // Staging datapath and acknowledge; a stage with nothing pending loads a null packet.
    always_comb begin
        header_d      = header_q;
        sub_0_d       = sub_0_q;
        sub_1_d       = sub_1_q;
        sub_2_d       = sub_2_q;
        sub_3_d       = sub_3_q;
        packet_type_d = packet_type_q;
        ack           = 4'd0;
        if (stage && !reset) begin
            if (sel_valid) begin
                header_d      = src_header[24*sel +: 24];
                sub_0_d       = src_sub[224*sel +: 56];
                sub_1_d       = src_sub[224*sel + 56 +: 56];
                sub_2_d       = src_sub[224*sel + 112 +: 56];
                sub_3_d       = src_sub[224*sel + 168 +: 56];
                packet_type_d = {1'b0, sel} + 3'd1;
                ack[sel]      = 1'b1;
            end else begin
                header_d      = 24'd0;
                sub_0_d       = 56'd0;
                sub_1_d       = 56'd0;
                sub_2_d       = 56'd0;
                sub_3_d       = 56'd0;
                packet_type_d = 3'd0;
            end
        end
    end

    // Pending flags: a new request in the same cycle as its clear keeps the flag set.
    always_comb begin
        clr_acr       = ack[0];
        clr_avi       = ack[2];
        clr_aif       = ack[3];
        acr_pend_d    = src_req[0] | (acr_pend_q & ~clr_acr);
        avi_pend_d    = video_field_end | (avi_pend_q & ~clr_avi);
        aif_pend_d    = video_field_end | (aif_pend_q & ~clr_aif);
        acr_overrun_d = acr_overrun_q | (src_req[0] & acr_pend_q & ~clr_acr);
    end

    // State, pending and staged packet registers.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            acr_pend_q    <= 1'b0;
            avi_pend_q    <= 1'b0;
            aif_pend_q    <= 1'b0;
            acr_overrun_q <= 1'b0;
            header_q      <= 24'd0;
            sub_0_q       <= 56'd0;
            sub_1_q       <= 56'd0;
            sub_2_q       <= 56'd0;
            sub_3_q       <= 56'd0;
            packet_type_q <= 3'd0;
        end else begin
            state_q       <= state_d;
            acr_pend_q    <= acr_pend_d;
            avi_pend_q    <= avi_pend_d;
            aif_pend_q    <= aif_pend_d;
            acr_overrun_q <= acr_overrun_d;
            header_q      <= header_d;
            sub_0_q       <= sub_0_d;
            sub_1_q       <= sub_1_d;
            sub_2_q       <= sub_2_d;
            sub_3_q       <= sub_3_d;
            packet_type_q <= packet_type_d;
        end
    end

    assign src_ack     = ack;
    assign header      = header_q;
    assign sub_0       = sub_0_q;
    assign sub_1       = sub_1_q;
    assign sub_2       = sub_2_q;
    assign sub_3       = sub_3_q;
    assign packet_type = packet_type_q;
    assign acr_overrun = acr_overrun_q;

endmodule
